// File: rtl/code_conv_sequencer.sv
// code_conv_sequencer
//
// Upstream sequencer for the combinational 4-bit code converter. It accepts one
// nibble plus mode per valid/ready transaction, holds the converter data lines
// and mode selects stable for SETTLE_CYCLES cycles, then captures the result bus
// that matches the mode and offers it downstream with a valid/ready handshake.
//
// Parameters:
//   SETTLE_CYCLES  cycles the converter inputs are held before sampling (1..15)
//
// Optional feature macro: CONV_RANGE_CHECK_EN
//   When defined, BCD->excess-3 (mode 01) with data > 9 and excess-3->BCD
//   (mode 11) with data < 3 or > 12 raise out_err and force out_data to 0000.
//   When undefined, out_err is tied low and out_data is the raw selected bus.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       upstream handshake (in_ready is registered)
//   in_data[3:0], in_mode   nibble and conversion select
//   A,B,C,D, S2,S1          converter data lines / mode selects (registered)
//   o0..o3[3:0]             converter result buses for modes 00..11
//   out_valid/out_ready     downstream handshake
//   out_data, out_mode      converted nibble and the mode it was produced under
//   out_err                 input outside the legal code range
//
// State table:
//   state    | meaning
//   ST_IDLE  | in_ready=1, waiting for in_valid; converter inputs hold last value
//   ST_DRIVE | converter inputs held, settle counter running down to 0
//   ST_HOLD  | out_valid=1, result held until out_ready

module code_conv_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [1:0] in_mode,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       S2,
    output logic       S1,
    input  logic [3:0] o0,
    input  logic [3:0] o1,
    input  logic [3:0] o2,
    input  logic [3:0] o3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_mode,
    output logic       out_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // The counter expires on the SETTLE_CYCLES-th edge after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] data_q, data_d;
    logic [1:0] mode_q, mode_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q, out_data_d;
    logic [1:0] out_mode_q, out_mode_d;
    logic       out_err_q, out_err_d;

    logic [3:0] sel_bus;
    logic       range_bad;

    always_comb begin
        sel_bus = o0;
        case (mode_q)
            2'b00:   sel_bus = o0;
            2'b01:   sel_bus = o1;
            2'b10:   sel_bus = o2;
            default: sel_bus = o3;
        endcase
    end

`ifdef CONV_RANGE_CHECK_EN
    // Checked against the held data, i.e. what the converter actually saw.
    always_comb begin
        range_bad = 1'b0;
        case (mode_q)
            2'b01:   range_bad = (data_q > 4'd9);
            2'b11:   range_bad = (data_q < 4'd3) || (data_q > 4'd12);
            default: range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    out_data_d  = range_bad ? 4'b0000 : sel_bus;
                    out_mode_d  = mode_q;
                    out_err_d   = range_bad;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                // out_valid_q is always 1 here, so out_ready alone completes it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Registered ready: depends only on the next state, never on out_ready
        // combinationally at the output.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            data_q      <= 4'd0;
            mode_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'd0;
            out_mode_q  <= 2'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign A         = data_q[3];
    assign B         = data_q[2];
    assign C         = data_q[1];
    assign D         = data_q[0];
    assign S2        = mode_q[1];
    assign S1        = mode_q[0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/code_conv_sequencer.md
# code_conv_sequencer

- Upstream sequencer for the 4-bit code converter. Drives its A/B/C/D data lines and S2/S1 mode selects.
- Accepts one nibble plus mode per valid/ready transaction and holds the converter inputs stable for a settle window.
- Captures the converter output bus that matches the mode and presents it downstream with a valid/ready handshake.
- Lets the purely combinational converter sit inside a clocked datapath.

## Interface
- SETTLE_CYCLES, 2: cycles the converter inputs are held before the output is sampled; legal range 1..15.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream offers a transaction.
- in_ready  output  1  block can accept a transaction.
- in_data  input  4  nibble to convert; bit 3 is MSB.
- in_mode  input  2  conversion select:
  - 00: binary→gray.
  - 01: BCD→excess-3.
  - 10: gray→binary.
  - 11: excess-3→BCD.
- A, B, C, D  output  1 each  converter data lines: A=in_data[3], B=in_data[2], C=in_data[1], D=in_data[0].
- S2, S1  output  1 each  converter mode selects: S2=in_mode[1], S1=in_mode[0].
- o0, o1, o2, o3  input  4 each  converter result buses for modes 00, 01, 10, 11.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_data  output  4  converted nibble.
- out_mode  output  2  mode the result was produced under.
- out_err  output  1  input was outside the legal code range (see Configuration).

## Operation
- FSM has three states: IDLE, DRIVE, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid=1, register in_data/in_mode onto A..D and S2/S1.
  - Load the settle counter with SETTLE_CYCLES-1 and go to DRIVE.
- DRIVE:
  - in_ready=0. The counter decrements each cycle.
  - When the counter is 0, capture the bus selected by the held mode (00→o0, 01→o1, 10→o2, 11→o3) into out_data. Load out_mode and out_err, then go to HOLD.
- HOLD:
  - out_valid=1. out_data, out_mode and out_err stay stable until out_valid && out_ready.
  - On that edge: go to IDLE, out_valid=0.
- A..D and S2/S1 keep the last applied values in IDLE and HOLD. They change only on an accept edge.
- in_data/in_mode are ignored while in_ready=0. Only one transaction is in flight; no buffering beyond one entry.
- Reset while rst_n=0 at a rising edge:
  - state=IDLE, counter=0.
  - A, B, C, D, S2, S1 = 0.
  - out_valid=0, out_data=0000, out_mode=00, out_err=0.
  - in_ready=1 from the first cycle after reset is released.
  - Any in-flight transaction is dropped and no result is emitted.

## Timing
- Accept on edge E0: A..D and S2/S1 are valid after E0.
- out_valid rises after edge E0+SETTLE_CYCLES. With the default this is 2 edges after acceptance, giving the converter 2 full cycles of stable inputs.
- If out_ready=1 while out_valid=1, the result is consumed on that edge and in_ready=1 in the next cycle.
- Back-to-back throughput with out_ready tied high: one transaction per SETTLE_CYCLES+2 cycles (4 with the default).
- in_ready is a registered function of state, with no combinational path from out_ready.
- out_valid and out_data are registered.

## Configuration
- Macro: CONV_RANGE_CHECK_EN.
- Defined: at capture, out_err=1 and out_data is forced to 0000 in either case:
  - mode 01 with held data > 9;
  - mode 11 with held data < 3 or > 12.
- Defined: modes 00 and 10 never flag.
- Not defined: out_err is constant 0 and out_data is always the raw selected bus. No range-check logic is synthesised.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, A..D=0, S2=S1=0, in_ready=1 the cycle after release.
- Binary→gray: in_data=1011, in_mode=00, out_ready=1, real converter attached → S2S1=00, out_data=1110, out_mode=00, out_valid rises 2 edges after accept.
- BCD→excess-3: in_data=0111, mode 01 → out_data=1010.
- Excess-3→BCD: in_data=1100, mode 11 → out_data=1001.
- Backpressure: complete a mode-10 transaction on 0110 (gray→binary) with out_ready=0 for 5 cycles:
  - out_data=0100 stable, out_valid held, in_ready=0, a new in_valid is ignored.
  - Raise out_ready → consumed on that edge; in_ready=1 next cycle.
- Range check:
  - With CONV_RANGE_CHECK_EN: mode 01 with in_data=1101 → out_err=1, out_data=0000.
  - Without the macro: the same stimulus gives out_err=0 and out_data equal to the o1 bus.
- Reset mid-DRIVE with SETTLE_CYCLES=4: pulse rst_n low 2 cycles after accept → no out_valid pulse ever occurs and all outputs return to reset values.
